// File: rtl/uart_loopback_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : uart_loopback_if                                          |
// | Desc   : Serial line and status signals of the UART echo block.   |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
interface uart_loopback_if;
    logic       i_UART_RX;
    logic       o_UART_TX;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Tx_Active;
    logic       o_Tx_Done;

    modport slave (
        input  i_UART_RX,
        output o_UART_TX, o_Rx_DV, o_Rx_Byte, o_Tx_Active, o_Tx_Done
    );

    modport master (
        output i_UART_RX,
        input  o_UART_TX, o_Rx_DV, o_Rx_Byte, o_Tx_Active, o_Tx_Done
    );
endinterface
`default_nettype wire

// File: rtl/uart_loopback.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : uart_loopback                                             |
// | Desc   : 8N1 UART receiver, one-byte pending buffer and echoing   |
// |          transmitter with a fixed clock-to-baud divider.           |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module uart_loopback #(
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic       i_Clk,
    input  wire logic       i_Rst,
    uart_loopback_if.slave  u_if
);
    localparam int               c_CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [c_CW-1:0]  c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0]  c_PRE_LAST = c_CW'(CLKS_PER_BIT - 2);
    localparam logic [c_CW-1:0]  c_HALF     = c_CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } state_t;

    logic            r_rx_meta;
    logic            r_rx_sync;
    state_t          r_rx_state;
    logic [c_CW-1:0] r_rx_cnt;
    logic [2:0]      r_rx_idx;
    logic [7:0]      r_rx_byte;
    logic            r_rx_dv;

    logic            r_pend;
    logic [7:0]      r_pend_byte;

    state_t          r_tx_state;
    logic [c_CW-1:0] r_tx_cnt;
    logic [2:0]      r_tx_idx;
    logic [7:0]      r_tx_data;
    logic            r_tx;
    logic            r_tx_active;
    logic            r_tx_done;

    logic            w_tx_accept;

    assign w_tx_accept = (r_tx_state == ST_IDLE) && r_pend;

    // Receiver: start edge qualified at half a bit, then one sample per bit period.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_byte  <= '0;
            r_rx_dv    <= 1'b0;
        end else begin
            r_rx_meta <= u_if.i_UART_RX;
            r_rx_sync <= r_rx_meta;
            r_rx_dv   <= 1'b0;
            case (r_rx_state)
                ST_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_idx <= '0;
                    if (!r_rx_sync)
                        r_rx_state <= ST_START;
                end
                ST_START: begin
                    if (r_rx_cnt == c_HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt            <= '0;
                        r_rx_byte[r_rx_idx] <= r_rx_sync;
                        if (r_rx_idx == 3'd7) begin
                            r_rx_idx   <= '0;
                            r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Stop level is deliberately not checked; the byte is delivered regardless.
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_dv    <= 1'b1;
                        r_rx_state <= ST_CLEANUP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_CLEANUP: r_rx_state <= ST_IDLE;
                default:    r_rx_state <= ST_IDLE;
            endcase
        end
    end

    // A new byte wins over one still waiting, even when the transmitter accepts the old one.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_pend      <= 1'b0;
            r_pend_byte <= '0;
        end else if (r_rx_dv) begin
            r_pend      <= 1'b1;
            r_pend_byte <= r_rx_byte;
        end else if (w_tx_accept) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_tx_state  <= ST_IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_tx_data   <= '0;
            r_tx        <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_tx_state)
                ST_IDLE: begin
                    r_tx     <= 1'b1;
                    r_tx_cnt <= '0;
                    r_tx_idx <= '0;
                    if (r_pend) begin
                        r_tx_data   <= r_pend_byte;
                        r_tx_active <= 1'b1;
                        r_tx        <= 1'b0;
                        r_tx_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= r_tx_data[0];
                        r_tx_state <= ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == 3'd7) begin
                            r_tx_idx   <= '0;
                            r_tx       <= 1'b1;
                            r_tx_state <= ST_STOP;
                        end else begin
                            r_tx_idx  <= r_tx_idx + 3'd1;
                            r_tx      <= r_tx_data[1];
                            r_tx_data <= r_tx_data >> 1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_CLEANUP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        // Registered one early so the pulse coincides with the final stop cycle.
                        if (r_tx_cnt == c_PRE_LAST) begin
                            r_tx_done   <= 1'b1;
                            r_tx_active <= 1'b0;
                        end
                    end
                end
                ST_CLEANUP: begin
                    r_tx       <= 1'b1;
                    r_tx_state <= ST_IDLE;
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    assign u_if.o_UART_TX   = r_tx;
    assign u_if.o_Rx_DV     = r_rx_dv;
    assign u_if.o_Rx_Byte   = r_rx_byte;
    assign u_if.o_Tx_Active = r_tx_active;
    assign u_if.o_Tx_Done   = r_tx_done;
endmodule
`default_nettype wire

// File: tb/tb_uart_loopback.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_uart_loopback                                          |
// | Desc   : Self-checking bench for the UART echo block.              |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_uart_loopback;
    localparam int CPB   = 64;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    uart_loopback_if bus ();

    uart_loopback #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .u_if  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rxdv_q[$];
    logic [9:0] txf_q[$];
    int         txbad_q[$];
    int         txstart_q[$];
    int         done_q[$];
    int         tx_low_cycles = 0;

    // Expected line image of one 8N1 frame, first bit in position 0.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.o_Rx_DV === 1'b1) rxdv_q.push_back(bus.o_Rx_Byte);
        if (!rst && bus.o_Tx_Done === 1'b1) done_q.push_back(cyc);
        if (!rst && bus.o_UART_TX !== 1'b1) tx_low_cycles = tx_low_cycles + 1;
    end

    // Line decoder: captures each TX frame and counts level or o_Tx_Active irregularities.
    initial begin : tx_mon
        logic       prev;
        logic       lvl;
        logic [9:0] f;
        int         bad;
        int         t0;
        bit         aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && bus.o_UART_TX === 1'b0) begin
                t0 = cyc; bad = 0; aborted = 0; f = '0; lvl = 1'b0;
                for (int n = 0; n < FRAME; n++) begin
                    if (n > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    if (n % CPB == 0) begin
                        lvl = bus.o_UART_TX;
                        f   = {lvl, f[9:1]};
                    end else if (bus.o_UART_TX !== lvl) begin
                        bad++;
                    end
                    if (bus.o_Tx_Active !== (n != FRAME - 1)) bad++;
                end
                if (!aborted) begin
                    txf_q.push_back(f);
                    txbad_q.push_back(bad);
                    txstart_q.push_back(t0);
                end
                prev = rst ? 1'b1 : bus.o_UART_TX;
            end else begin
                prev = bus.o_UART_TX;
            end
        end
    end

    task automatic clear_obs();
        rxdv_q.delete(); txf_q.delete(); txbad_q.delete();
        txstart_q.delete(); done_q.delete();
        tx_low_cycles = 0;
    endtask

    task automatic drive(input logic lvl, input int n);
        bus.i_UART_RX = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int start_len);
        drive(1'b0, start_len);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(1'b1, CPB);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_q.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: tx_done pulses=%0d, required %0d within %0d cycles",
                     tag, done_q.size(), n, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_UART_RX = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({bus.o_UART_TX, bus.o_Tx_Active, bus.o_Tx_Done, bus.o_Rx_DV} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_outputs: tx=%b act=%b done=%b dv=%b, required 1 0 0 0",
                         bus.o_UART_TX, bus.o_Tx_Active, bus.o_Tx_Done, bus.o_Rx_DV);
            end
            checks++;
            if (bus.o_Rx_Byte !== 8'h00) begin
                failures++;
                $display("FAIL reset_rx_byte: got %h, required 00", bus.o_Rx_Byte);
            end
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.o_UART_TX, bus.o_Tx_Active, bus.o_Tx_Done, bus.o_Rx_DV} !== 4'b1000) begin
            failures++;
            $display("FAIL post_reset_idle: tx=%b act=%b done=%b dv=%b, required 1 0 0 0",
                     bus.o_UART_TX, bus.o_Tx_Active, bus.o_Tx_Done, bus.o_Rx_DV);
        end
    endtask

    task automatic test_stretched_start();
        logic [7:0] b = 8'h3F;
        clear_obs();
        send_frame(b, CPB + (CPB * 3) / 10);
        wait_done(1, 2 * FRAME, "stretch");
        checks++;
        if (rxdv_q.size() != 1 || rxdv_q[0] !== b) begin
            failures++;
            $display("FAIL stretch_rx: dv pulses=%0d byte=%h, required 1 pulse byte %h",
                     rxdv_q.size(), rxdv_q.size() > 0 ? rxdv_q[0] : 8'hxx, b);
        end
        checks++;
        if (txf_q.size() != 1 || txf_q[0] !== frame_of(b) || txbad_q[0] != 0) begin
            failures++;
            $display("FAIL stretch_tx_frame: frames=%0d bits=%b irregular=%0d, required 1 frame bits %b irregular 0",
                     txf_q.size(), txf_q.size() > 0 ? txf_q[0] : 10'bx,
                     txbad_q.size() > 0 ? txbad_q[0] : -1, frame_of(b));
        end
        checks++;
        if (done_q.size() != 1 || txstart_q.size() != 1 || done_q[0] != txstart_q[0] + FRAME - 1) begin
            failures++;
            $display("FAIL stretch_tx_done: pulses=%0d at cycle %0d, required 1 pulse at last stop cycle %0d",
                     done_q.size(), done_q.size() > 0 ? done_q[0] : -1,
                     txstart_q.size() > 0 ? txstart_q[0] + FRAME - 1 : -1);
        end
    endtask

    task automatic test_nominal_echo();
        logic [7:0] pats [3];
        pats = '{8'hAB, 8'h00, 8'hFF};
        for (int p = 0; p < 3; p++) begin
            clear_obs();
            send_frame(pats[p], CPB);
            wait_done(1, 2 * FRAME, "nominal");
            checks++;
            if (rxdv_q.size() != 1 || rxdv_q[0] !== pats[p]) begin
                failures++;
                $display("FAIL nominal_rx_%h: dv pulses=%0d byte=%h, required 1 pulse byte %h", pats[p],
                         rxdv_q.size(), rxdv_q.size() > 0 ? rxdv_q[0] : 8'hxx, pats[p]);
            end
            checks++;
            if (txf_q.size() != 1 || txf_q[0] !== frame_of(pats[p]) || txbad_q[0] != 0) begin
                failures++;
                $display("FAIL nominal_tx_%h: frames=%0d bits=%b irregular=%0d, required 1 frame bits %b irregular 0",
                         pats[p], txf_q.size(), txf_q.size() > 0 ? txf_q[0] : 10'bx,
                         txbad_q.size() > 0 ? txbad_q[0] : -1, frame_of(pats[p]));
            end
            checks++;
            if (done_q.size() != 1 || txstart_q.size() != 1 || done_q[0] != txstart_q[0] + FRAME - 1) begin
                failures++;
                $display("FAIL nominal_done_%h: pulses=%0d, required exactly 1 at last stop cycle",
                         pats[p], done_q.size());
            end
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        drive(1'b0, CPB / 4);
        drive(1'b1, 2 * FRAME);
        checks++;
        if (rxdv_q.size() != 0 || done_q.size() != 0 || tx_low_cycles != 0) begin
            failures++;
            $display("FAIL glitch: dv pulses=%0d done pulses=%0d tx low cycles=%0d, required 0 0 0",
                     rxdv_q.size(), done_q.size(), tx_low_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [2];
        exp = '{8'h55, 8'hA5};
        clear_obs();
        send_frame(exp[0], CPB);
        send_frame(exp[1], CPB);
        wait_done(2, 3 * FRAME, "b2b");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rxdv_q.size() != 2 || rxdv_q[i] !== exp[i]) begin
                failures++;
                $display("FAIL b2b_rx_%0d: dv pulses=%0d byte=%h, required 2 pulses byte %h", i,
                         rxdv_q.size(), rxdv_q.size() > i ? rxdv_q[i] : 8'hxx, exp[i]);
            end
            checks++;
            if (txf_q.size() != 2 || txf_q[i] !== frame_of(exp[i]) || txbad_q[i] != 0) begin
                failures++;
                $display("FAIL b2b_tx_%0d: frames=%0d bits=%b, required 2 frames bits %b", i,
                         txf_q.size(), txf_q.size() > i ? txf_q[i] : 10'bx, frame_of(exp[i]));
            end
        end
        checks++;
        if (done_q.size() != 2 || done_q[1] - done_q[0] < FRAME + 1 || done_q[1] - done_q[0] > FRAME + 3) begin
            failures++;
            $display("FAIL b2b_done_spacing: pulses=%0d spacing=%0d, required 2 pulses spacing %0d..%0d",
                     done_q.size(), done_q.size() == 2 ? done_q[1] - done_q[0] : -1, FRAME + 1, FRAME + 3);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] nb = 8'h96;
        clear_obs();
        send_frame(8'hC3, CPB);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (bus.o_Tx_Active !== 1'b1) begin
            failures++;
            $display("FAIL midrst_precondition: tx_active=%b, required 1", bus.o_Tx_Active);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.o_UART_TX, bus.o_Tx_Active, bus.o_Tx_Done} !== 3'b100) begin
            failures++;
            $display("FAIL midrst_outputs: tx=%b act=%b done=%b, required 1 0 0",
                     bus.o_UART_TX, bus.o_Tx_Active, bus.o_Tx_Done);
        end
        rst = 1'b0;
        repeat (FRAME) @(negedge clk);
        checks++;
        if (done_q.size() != 0 || txf_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_abandon: done pulses=%0d frames=%0d, required 0 0",
                     done_q.size(), txf_q.size());
        end
        clear_obs();
        send_frame(nb, CPB);
        wait_done(1, 2 * FRAME, "midrst_next");
        checks++;
        if (rxdv_q.size() != 1 || rxdv_q[0] !== nb || txf_q.size() != 1 || txf_q[0] !== frame_of(nb)
            || txbad_q[0] != 0) begin
            failures++;
            $display("FAIL midrst_next_echo: dv=%0d byte=%h frames=%0d bits=%b, required 1 %h 1 %b",
                     rxdv_q.size(), rxdv_q.size() > 0 ? rxdv_q[0] : 8'hxx, txf_q.size(),
                     txf_q.size() > 0 ? txf_q[0] : 10'bx, nb, frame_of(nb));
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp[$];
        logic [7:0] b;
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            exp.push_back(b);
            send_frame(b, CPB + int'($urandom_range(0, CPB / 4)));
        end
        wait_done(5, 3 * FRAME, "random");
        checks++;
        if (rxdv_q.size() != 5 || txf_q.size() != 5 || done_q.size() != 5) begin
            failures++;
            $display("FAIL random_counts: dv=%0d frames=%0d done=%0d, required 5 5 5",
                     rxdv_q.size(), txf_q.size(), done_q.size());
        end
        for (int i = 0; i < 5 && i < txf_q.size() && i < rxdv_q.size(); i++) begin
            checks++;
            if (rxdv_q[i] !== exp[i] || txf_q[i] !== frame_of(exp[i]) || txbad_q[i] != 0) begin
                failures++;
                $display("FAIL random_echo_%0d: rx=%h bits=%b irregular=%0d, required rx %h bits %b irregular 0",
                         i, rxdv_q[i], txf_q[i], txbad_q[i], exp[i], frame_of(exp[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stretched_start();
        test_nominal_echo();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_loopback.md
Name: uart_loopback

Overview:
- UART echo block: deserialises bytes arriving on the serial RX line and retransmits each byte unchanged on the serial TX line.
- Format is 8N1, LSB first, with a fixed clock-to-baud divider.
- Contains a receiver FSM, a one-byte pending buffer and a transmitter FSM.
- Used as the board-level UART bring-up/loopback top.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_UART_RX  input  1  asynchronous serial input, idle high.
- o_UART_TX  output  1  serial output, idle high.
- o_Rx_DV  output  1  one-cycle pulse when a byte has been received.
- o_Rx_Byte  output  8  last received byte, valid from the o_Rx_DV pulse onward.
- o_Tx_Active  output  1  high while a frame is being transmitted.
- o_Tx_Done  output  1  one-cycle pulse at the end of each transmitted stop bit.

Behaviour:
Reset (sampled on i_Clk while i_Rst=1):
- Both FSMs go IDLE.
- o_UART_TX=1; o_Rx_DV=0; o_Rx_Byte=0; o_Tx_Active=0; o_Tx_Done=0.
- Pending buffer cleared; counters cleared.
- A frame in flight is abandoned and TX returns high in the next cycle.

RX synchroniser:
- i_UART_RX passes through a 2-FF synchroniser before use, giving 2 cycles of latency.
- The synchroniser flops reset to 1.

RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
- IDLE: counter=0; on synchronised RX=0 go to START.
- START: count to (CLKS_PER_BIT-1)/2.
  - If the line is still 0 at that point, clear the counter and go to DATA.
  - Otherwise it is a glitch; return to IDLE.
- DATA: every CLKS_PER_BIT cycles, sample bit i into o_Rx_Byte[i], i=0..7, LSB first. After bit 7 go to STOP.
- STOP: wait CLKS_PER_BIT cycles (the sample lands mid-stop-bit), then pulse o_Rx_DV for 1 cycle and go to CLEANUP.
  - The stop-bit value is not checked; a framing error still delivers the byte.
- CLEANUP: 1 cycle, then IDLE.
- Tolerance: sampling is mid-bit, so a start bit stretched by up to about 0.4 bit period must still decode correctly.

Pending buffer:
- On o_Rx_DV, the byte is stored and a pending flag is set.
- If a byte is already pending when another o_Rx_DV arrives, the new byte overwrites it (last-wins).
- The flag clears when the TX FSM accepts the byte.

TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
- IDLE: o_UART_TX=1.
  - If the pending flag is set, latch the byte, set o_Tx_Active=1, clear the flag, and go to START.
  - When the pending buffer is empty, the byte is accepted within 2 cycles of o_Rx_DV.
- START: drive 0 for CLKS_PER_BIT cycles.
- DATA: drive bits 0..7, LSB first, CLKS_PER_BIT cycles each.
- STOP: drive 1 for CLKS_PER_BIT cycles.
  - In the last cycle of STOP, pulse o_Tx_Done for 1 cycle and drop o_Tx_Active.
  - Then go to CLEANUP.
- CLEANUP: 1 cycle with o_UART_TX=1, then IDLE.

Timing and concurrency:
- Frame length is exactly 10*CLKS_PER_BIT cycles, from the first START cycle through the end of STOP.
- RX and TX run concurrently and independently, so back-to-back received frames are echoed back-to-back.

Counters:
- Width is clog2(CLKS_PER_BIT)+1.
- Counters never wrap mid-bit; they reset at each bit boundary.

Test Plan:
1. Reset: hold i_Rst=1 for 5 cycles, then release. Required: o_UART_TX=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0 throughout.
2. Echo 0x3F, with RX start bit stretched to 8680+1000 ns at 100 MHz. Required:
   - o_Rx_DV pulses once with o_Rx_Byte=0x3F.
   - TX emits 0, then 1,1,1,1,1,1,0,0, then 1, each bit 868 cycles.
   - o_Tx_Done pulses exactly once.
3. Echo 0xAB and 0x00/0xFF, nominal timing. Required: TX bit pattern matches the input LSB first and o_Tx_Done pulses once per byte.
4. Glitch: RX low for 200 cycles (less than half a bit), then high. Required: no o_Rx_DV, TX stays 1.
5. Back-to-back: send 0x55 then 0xA5 with no idle gap. Required:
   - Two o_Rx_DV pulses and two echoed frames in order.
   - Two o_Tx_Done pulses, 10*868+1 to 10*868+3 cycles apart.
6. Reset mid-frame: assert i_Rst during TX DATA. Required: next cycle o_UART_TX=1, o_Tx_Active=0, and no o_Tx_Done; the next byte then echoes normally.
